// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module alu_arbiter (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic        skip0,
  input  logic        skip1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] y,
  output logic        bga,
  output logic        bea,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_OR   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MULT = OP_W'(7);
  localparam logic [OP_W-1:0] OP_NOTA = OP_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic              skip;
  } alu_req_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_issue;
  logic              w_complete;
  logic              w_win;
  alu_req_t          w_sel;
  alu_req_t          r_req;
  logic              r_owner;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_bga;
  logic              w_bea;

  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_y;
  logic              r_bga;
  logic              r_bea;
  logic              r_busy;

  // Winner select; only meaningful when at least one request is high.
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_win = ~req0;
`else
  logic r_ptr;

  assign w_win = (req0 & req1) ? ~r_ptr : ~req0;

  // Pointer remembers the last granted port; reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= 1'b1;
    end else if (w_issue) begin
      r_ptr <= w_win;
    end
  end
`endif

  assign w_sel = w_win ? {a1, b1, op1, skip1} : {a0, b0, op0, skip0};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: arbitrate in IDLE/DONE, evaluate for one cycle in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (req0 | req1) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_complete  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shared ALU driven only from the latched operand register.
  always_comb begin
    w_alu_y = '0;
    case (r_req.op)
      OP_OR:   w_alu_y = r_req.a | r_req.b;
      OP_AND:  w_alu_y = r_req.a & r_req.b;
      OP_XOR:  w_alu_y = r_req.a ^ r_req.b;
      OP_ADD:  w_alu_y = r_req.a + r_req.b;
      OP_SUB:  w_alu_y = r_req.a - r_req.b;
      OP_SHL:  w_alu_y = r_req.b[5] ? '0 : (r_req.a << r_req.b[4:0]);
      OP_SHR:  w_alu_y = r_req.b[5] ? '0 : (r_req.a >> r_req.b[4:0]);
      OP_MULT: w_alu_y = r_req.a * r_req.b;
      OP_NOTA: w_alu_y = ~r_req.a;
      default: w_alu_y = '0;
    endcase
    if (r_req.skip) begin
      w_alu_y = r_req.b;
    end
  end

  assign w_bga = (r_req.b > r_req.a);
  assign w_bea = (r_req.b == r_req.a);

  // Operand capture and owner tracking on grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_req   <= '0;
      r_owner <= 1'b0;
    end else if (w_issue) begin
      r_req   <= w_sel;
      r_owner <= w_win;
    end
  end

  // Registered handshake pulses and result; result holds until next completion.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_y     <= '0;
      r_bga   <= 1'b0;
      r_bea   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_gnt0  <= w_issue & ~w_win;
      r_gnt1  <= w_issue & w_win;
      r_done0 <= w_complete & ~r_owner;
      r_done1 <= w_complete & r_owner;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_complete) begin
        r_y   <= w_alu_y;
        r_bga <= w_bga;
        r_bea <= w_bea;
      end
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign y     = r_y;
  assign bga   = r_bga;
  assign bea   = r_bea;
  assign busy  = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard of expected results checked on each done pulse.
module tb_alu_arbiter;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MULT = 4'd7;
  localparam logic [3:0] OP_NOTA = 4'd8;

  logic        clk;
  logic        nreset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        skip0, skip1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] y;
  logic        bga, bea, busy;

  typedef struct {
    logic        port;
    logic [31:0] y;
    logic        bga;
    logic        bea;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  logic tb_ptr;

  alu_arbiter dut (
    .clk    (clk),
    .nreset (nreset),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .op0    (op0),
    .op1    (op1),
    .skip0  (skip0),
    .skip1  (skip1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .y      (y),
    .bga    (bga),
    .bea    (bea),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_y(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic skip);
    logic [63:0] p;
    logic [5:0]  sh;
    sh = b[5:0];
    if (skip) return b;
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return (sh > 6'd31) ? 32'd0 : (a << sh);
      OP_SHR:  return (sh > 6'd31) ? 32'd0 : (a >> sh);
      OP_MULT: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      OP_NOTA: return ~a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic skip);
    exp_t e;
    e.port = port;
    e.y    = model_y(a, b, op, skip);
    e.bga  = (b > a);
    e.bea  = (b == a);
    sb.push_back(e);
  endtask

  task automatic check_done();
    exp_t e;
    chk("done_exclusive", 64'(done0 & done1), 64'd0);
    if (sb.size() == 0) begin
      chk("unexpected_done", 64'({done0, done1}), 64'd0);
    end else begin
      e = sb.pop_front();
      chk("done_port", 64'(done1), 64'(e.port));
      chk("y", 64'(y), 64'(e.y));
      chk("bga", 64'(bga), 64'(e.bga));
      chk("bea", 64'(bea), 64'(e.bea));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done0 || done1) check_done();
  endtask

  task automatic drive(input logic port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic skip);
    if (port) begin
      req1 = 1'b1; a1 = a; b1 = b; op1 = op; skip1 = skip;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; op0 = op; skip0 = skip;
    end
  endtask

  task automatic set_req(input logic port, input logic v);
    if (port) req1 = v;
    else      req0 = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({gnt0, gnt1, done0, done1, busy, bga, bea, y}), 64'd0);
  endtask

  task automatic run_single(input logic port, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic skip);
    drive(port, a, b, op, skip);
    push(port, a, b, op, skip);
    tick();
    chk("gnt_single", 64'({gnt0, gnt1}), port ? 64'd1 : 64'd2);
    chk("busy_gnt", 64'(busy), 64'd1);
    set_req(port, 1'b0);
    tick();
    chk("done_single", 64'({done0, done1}), port ? 64'd1 : 64'd2);
    chk("busy_done", 64'(busy), 64'd1);
    tb_ptr = port;
  endtask

  task automatic run_pair(input logic [31:0] xa0, input logic [31:0] xb0, input logic [3:0] xop0,
                          input logic [31:0] xa1, input logic [31:0] xb1, input logic [3:0] xop1);
    logic w;
`ifdef ALU_ARB_FIXED_PRIO_EN
    w = 1'b0;
`else
    w = ~tb_ptr;
`endif
    drive(1'b0, xa0, xb0, xop0, 1'b0);
    drive(1'b1, xa1, xb1, xop1, 1'b0);
    if (w == 1'b0) begin
      push(1'b0, xa0, xb0, xop0, 1'b0);
      push(1'b1, xa1, xb1, xop1, 1'b0);
    end else begin
      push(1'b1, xa1, xb1, xop1, 1'b0);
      push(1'b0, xa0, xb0, xop0, 1'b0);
    end
    tick();
    chk("gnt_pair_first", 64'({gnt0, gnt1}), w ? 64'd1 : 64'd2);
    set_req(w, 1'b0);
    tick();
    chk("done_pair_first", 64'({done0, done1}), w ? 64'd1 : 64'd2);
    chk("no_gnt_in_done", 64'({gnt0, gnt1}), 64'd0);
    tick();
    chk("gnt_pair_second", 64'({gnt0, gnt1}), w ? 64'd2 : 64'd1);
    set_req(~w, 1'b0);
    tick();
    chk("done_pair_second", 64'({done0, done1}), w ? 64'd2 : 64'd1);
    tb_ptr = ~w;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tb_ptr   = 1'b1;
    nreset   = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    op0 = '0; op1 = '0; skip0 = 1'b0; skip1 = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all_zero("idle_after_reset");
    end

    // Contention: port 0 wins the first tie, port 1 follows, next tie goes to port 0
    run_pair(32'd10, 32'd4, OP_SUB, 32'hFFFF_FFFF, 32'd2, OP_MULT);
    run_pair(32'd3, 32'd9, OP_ADD, 32'd6, 32'd6, OP_XOR);

    // Single operations, back-to-back from DONE
    run_single(1'b0, 32'd5, 32'd3, OP_ADD, 1'b0);
    run_single(1'b0, 32'd1, 32'd40, OP_SHL, 1'b0);
    run_single(1'b1, 32'd9, 32'd2, 4'hA, 1'b0);
    run_single(1'b0, 32'd0, 32'h1234, OP_ADD, 1'b1);
    run_single(1'b1, 32'd7, 32'd7, OP_XOR, 1'b0);
    run_single(1'b0, 32'h8000_0000, 32'd31, OP_SHR, 1'b0);
    run_single(1'b1, 32'h0F0F_1234, 32'd0, OP_NOTA, 1'b0);
    run_single(1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, OP_AND, 1'b0);
    run_single(1'b1, 32'hA000_0001, 32'h0500_0010, OP_OR, 1'b0);
    tick();
    chk("busy_idle", 64'({busy, gnt0, gnt1}), 64'd0);

    // Port 1 holds req; port 0 pulses only while BUSY and must be ignored
    drive(1'b1, 32'd100, 32'd23, OP_SUB, 1'b0);
    push(1'b1, 32'd100, 32'd23, OP_SUB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_gnt1", 64'({gnt0, gnt1}), 64'd1);
      drive(1'b0, 32'd55, 32'd55, OP_ADD, 1'b0);
      tick();
      chk("cont_done1", 64'({done0, done1}), 64'd1);
      req0 = 1'b0;
      if (i < 2) begin
        a1 = 32'd1000 + 32'(i); b1 = 32'd3 << i; op1 = OP_MULT;
        push(1'b1, a1, b1, op1, 1'b0);
      end else begin
        req1 = 1'b0;
      end
    end
    tb_ptr = 1'b1;
    tick();
    chk("cont_idle", 64'({busy, gnt0, gnt1, done0, done1}), 64'd0);

    // Reset while BUSY: operation abandoned, no done, outputs cleared
    drive(1'b0, 32'd1, 32'd2, OP_ADD, 1'b0);
    tick();
    chk("gnt_before_reset", 64'({gnt0, gnt1}), 64'd2);
    req0 = 1'b0;
    nreset = 1'b0;
    #1;
    chk_all_zero("reset_mid_busy");
    tick();
    chk_all_zero("in_reset_1");
    tick();
    chk_all_zero("in_reset_2");
    nreset = 1'b1;
    tb_ptr = 1'b1;
    tick();
    chk_all_zero("after_reset_release");

    // Normal operation resumes; pointer restored so port 0 wins the tie
    run_pair(32'd20, 32'd30, OP_ADD, 32'd4, 32'd1, OP_SHL);
    tick();
    chk("final_idle", 64'({busy, done0, done1}), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
